// File: rtl/instr_fetch.sv
// instr_fetch: instruction sequencer in front of the 16-bit DIN/Run/Done
// processor. Reads program words from a synchronous ROM, presents each
// instruction on DIN and holds Run high until the processor's Done. For
// mvi, the immediate word is prefetched so DIN carries it from the
// processor's second execute cycle onward.
//
// Ports:
//   Clock      in   system clock, rising edge
//   Reset      in   asynchronous, active-high reset
//   Start      in   level; in IDLE, begin fetching at the current PC
//   Stop       in   level; finish the current instruction, then go IDLE
//   Done       in   processor completes the current instruction this cycle
//   MemAddr    out  registered ROM address (acts as the ROM address register)
//   MemData    in   ROM read data, valid the cycle after MemAddr is loaded
//   DIN        out  word presented to the processor
//   Run        out  instruction valid / execute
//   PC         out  address of the current or next instruction
//   Busy       out  high in every state except IDLE
//   Halted     out  sticky; set when HALT_WORD is fetched
//   InstrCount out  number of completed instructions (wraps)

module instr_fetch #(
    parameter int unsigned        ADDR_W    = 5,
    parameter int unsigned        DATA_W    = 16,
    parameter logic [3:0]         MVI_OP    = 4'b0001,
    parameter logic [DATA_W-1:0]  HALT_WORD = 16'hFFFF
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Start,
    input  logic              Stop,
    input  logic              Done,
    output logic [ADDR_W-1:0] MemAddr,
    input  logic [DATA_W-1:0] MemData,
    output logic [DATA_W-1:0] DIN,
    output logic              Run,
    output logic [ADDR_W-1:0] PC,
    output logic              Busy,
    output logic              Halted,
    output logic [15:0]       InstrCount
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ADDR_I = 3'd1;
    localparam logic [2:0] S_DATA_I = 3'd2;
    localparam logic [2:0] S_ADDR_M = 3'd3;
    localparam logic [2:0] S_DATA_M = 3'd4;
    localparam logic [2:0] S_EXEC   = 3'd5;
    localparam logic [2:0] S_GAP    = 3'd6;

    logic [2:0]        state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] instr;
    logic [DATA_W-1:0] imm;
    logic              first_exec;
    logic              stop_seen;
    logic              halted;
    logic [15:0]       instr_count;

    logic              instr_is_mvi;
    logic              data_is_mvi;
    logic [ADDR_W-1:0] pc_step;

    assign instr_is_mvi = (instr[DATA_W-1 -: 4] == MVI_OP);
    assign data_is_mvi  = (MemData[DATA_W-1 -: 4] == MVI_OP);
    assign pc_step      = instr_is_mvi ? ADDR_W'(2) : ADDR_W'(1);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state       <= S_IDLE;
            pc          <= '0;
            mem_addr    <= '0;
            instr       <= '0;
            imm         <= '0;
            first_exec  <= 1'b0;
            stop_seen   <= 1'b0;
            halted      <= 1'b0;
            instr_count <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (Start && !Stop) begin
                        halted <= 1'b0;
                        state  <= S_ADDR_I;
                    end
                end
                S_ADDR_I: begin
                    if (Stop) begin
                        state <= S_IDLE;
                    end else begin
                        mem_addr <= pc;
                        state    <= S_DATA_I;
                    end
                end
                S_DATA_I: begin
                    if (Stop) begin
                        state <= S_IDLE;
                    end else begin
                        instr <= MemData;
                        if (MemData == HALT_WORD) begin
                            halted <= 1'b1;
                            state  <= S_IDLE;
                        end else if (data_is_mvi) begin
                            // Immediate lives at the next address, wrapping.
                            mem_addr <= pc + ADDR_W'(1);
                            state    <= S_ADDR_M;
                        end else begin
                            first_exec <= 1'b1;
                            stop_seen  <= 1'b0;
                            state      <= S_EXEC;
                        end
                    end
                end
                S_ADDR_M: begin
                    state <= Stop ? S_IDLE : S_DATA_M;
                end
                S_DATA_M: begin
                    if (Stop) begin
                        state <= S_IDLE;
                    end else begin
                        imm        <= MemData;
                        first_exec <= 1'b1;
                        stop_seen  <= 1'b0;
                        state      <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    first_exec <= 1'b0;
                    // Stop during execution is deferred until after GAP.
                    if (Stop) begin
                        stop_seen <= 1'b1;
                    end
                    if (Done) begin
                        instr_count <= instr_count + 16'd1;
                        pc          <= pc + pc_step;
                        state       <= S_GAP;
                    end
                end
                S_GAP: begin
                    state <= (Stop || stop_seen) ? S_IDLE : S_ADDR_I;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Run decodes straight from the async-reset state so a reset drops it
    // immediately. The processor latches IR on the first EXEC cycle, so the
    // immediate is only shown from the second cycle on.
    always_comb begin
        DIN = '0;
        if (state == S_EXEC) begin
            DIN = (first_exec || !instr_is_mvi) ? instr : imm;
        end
    end

    assign Run        = (state == S_EXEC);
    assign Busy       = (state != S_IDLE);
    assign MemAddr    = mem_addr;
    assign PC         = pc;
    assign Halted     = halted;
    assign InstrCount = instr_count;

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

    typedef struct packed {
        logic [15:0] din;
        logic        last;
    } exp_t;

    logic        Clock;
    logic        Reset;
    logic        Start;
    logic        Stop;
    logic        Done;
    logic [4:0]  MemAddr;
    logic [15:0] MemData;
    logic [15:0] DIN;
    logic        Run;
    logic [4:0]  PC;
    logic        Busy;
    logic        Halted;
    logic [15:0] InstrCount;

    logic [15:0] rom [32];
    exp_t        exp_q [$];
    int          tests = 0;
    int          fails = 0;

    instr_fetch #(
        .ADDR_W    (5),
        .DATA_W    (16),
        .MVI_OP    (4'b0001),
        .HALT_WORD (16'hFFFF)
    ) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .Start      (Start),
        .Stop       (Stop),
        .Done       (Done),
        .MemAddr    (MemAddr),
        .MemData    (MemData),
        .DIN        (DIN),
        .Run        (Run),
        .PC         (PC),
        .Busy       (Busy),
        .Halted     (Halted),
        .InstrCount (InstrCount)
    );

    // MemAddr is the ROM's address register, so data follows it directly.
    assign MemData = rom[MemAddr];

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Processor model: every Run cycle consumes one scoreboard entry, checks
    // DIN against it and raises Done on the entry flagged last.
    always @(negedge Clock) begin
        exp_t e;
        if (Reset || !Run) begin
            Done = 1'b0;
        end else if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL run_unexpected: Run high with DIN=%h, no instruction expected", DIN);
            Done = 1'b1;
        end else begin
            e = exp_q.pop_front();
            tests++;
            if (DIN !== e.din) begin
                fails++;
                $display("FAIL din: got %h, expected %h", DIN, e.din);
            end
            Done = e.last;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_for(input string name, input bit use_busy, input logic level, input int limit);
        bit seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge Clock);
            if ((use_busy ? Busy : Run) === level) seen = 1'b1;
        end
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL %s: timeout after %0d cycles waiting for level %0b", name, limit, level);
        end
    endtask

    task automatic apply_reset();
        Reset = 1'b1;
        Start = 1'b0;
        Stop  = 1'b0;
        repeat (2) @(negedge Clock);
        Reset = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 32; i++) rom[i] = 16'h0000;
    endtask

    task automatic pulse_start();
        @(negedge Clock);
        Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge Clock);
        tests++; if (Run !== 1'b0)       begin fails++; $display("FAIL reset_run: got %b, expected 0", Run); end
        tests++; if (PC !== 5'd0)        begin fails++; $display("FAIL reset_pc: got %0d, expected 0", PC); end
        tests++; if (MemAddr !== 5'd0)   begin fails++; $display("FAIL reset_memaddr: got %0d, expected 0", MemAddr); end
        tests++; if (DIN !== 16'h0000)   begin fails++; $display("FAIL reset_din: got %h, expected 0000", DIN); end
        tests++; if (Busy !== 1'b0)      begin fails++; $display("FAIL reset_busy: got %b, expected 0", Busy); end
        tests++; if (Halted !== 1'b0)    begin fails++; $display("FAIL reset_halted: got %b, expected 0", Halted); end
        tests++; if (InstrCount !== 16'd0) begin fails++; $display("FAIL reset_count: got %0d, expected 0", InstrCount); end
    endtask

    task automatic test_program();
        apply_reset();
        rom[0] = 16'h0280;
        rom[1] = 16'h1600;
        rom[2] = 16'h00AB;
        rom[3] = 16'hFFFF;
        exp_q.push_back('{din: 16'h0280, last: 1'b0});
        exp_q.push_back('{din: 16'h0280, last: 1'b1});
        exp_q.push_back('{din: 16'h1600, last: 1'b0});
        exp_q.push_back('{din: 16'h00AB, last: 1'b0});
        exp_q.push_back('{din: 16'h00AB, last: 1'b1});
        pulse_start();
        wait_for("mv_run", 1'b0, 1'b1, 20);
        wait_for("mv_gap", 1'b0, 1'b0, 20);
        tests++; if (PC !== 5'd1)          begin fails++; $display("FAIL mv_pc: got %0d, expected 1", PC); end
        tests++; if (InstrCount !== 16'd1) begin fails++; $display("FAIL mv_count: got %0d, expected 1", InstrCount); end
        tests++; if (Busy !== 1'b1)        begin fails++; $display("FAIL gap_busy: got %b, expected 1", Busy); end
        repeat (2) @(negedge Clock);
        tests++; if (MemAddr !== 5'd1)     begin fails++; $display("FAIL gap_len: MemAddr got %0d, expected 1", MemAddr); end
        wait_for("mvi_run", 1'b0, 1'b1, 20);
        wait_for("mvi_gap", 1'b0, 1'b0, 20);
        tests++; if (PC !== 5'd3)          begin fails++; $display("FAIL mvi_pc: got %0d, expected 3", PC); end
        tests++; if (InstrCount !== 16'd2) begin fails++; $display("FAIL mvi_count: got %0d, expected 2", InstrCount); end
        wait_for("halt_idle", 1'b1, 1'b0, 20);
        tests++; if (Halted !== 1'b1)      begin fails++; $display("FAIL halt_flag: got %b, expected 1", Halted); end
        tests++; if (PC !== 5'd3)          begin fails++; $display("FAIL halt_pc: got %0d, expected 3", PC); end
        tests++; if (exp_q.size() != 0)    begin fails++; $display("FAIL prog_queue: %0d entries left, expected 0", exp_q.size()); end
        pulse_start();
        tests++; if (Halted !== 1'b0)      begin fails++; $display("FAIL restart_clear: Halted got %b, expected 0", Halted); end
        tests++; if (Busy !== 1'b1)        begin fails++; $display("FAIL restart_busy: got %b, expected 1", Busy); end
        wait_for("rehalt_idle", 1'b1, 1'b0, 20);
        tests++; if (Halted !== 1'b1)      begin fails++; $display("FAIL rehalt_flag: got %b, expected 1", Halted); end
        tests++; if (PC !== 5'd3)          begin fails++; $display("FAIL rehalt_pc: got %0d, expected 3", PC); end
    endtask

    task automatic test_wrap();
        apply_reset();
        // 0: mvi with immediate FFFF, 2..30: nops, 31: mvi wrapping to 0, 1: halt
        rom[0]  = 16'h1234;
        rom[1]  = 16'hFFFF;
        rom[31] = 16'h1500;
        exp_q.push_back('{din: 16'h1234, last: 1'b0});
        exp_q.push_back('{din: 16'hFFFF, last: 1'b1});
        for (int i = 2; i <= 30; i++) exp_q.push_back('{din: 16'h0000, last: 1'b1});
        exp_q.push_back('{din: 16'h1500, last: 1'b0});
        exp_q.push_back('{din: 16'h1234, last: 1'b1});
        pulse_start();
        wait_for("wrap_idle", 1'b1, 1'b0, 400);
        tests++; if (PC !== 5'd1)           begin fails++; $display("FAIL wrap_pc: got %0d, expected 1", PC); end
        tests++; if (InstrCount !== 16'd31) begin fails++; $display("FAIL wrap_count: got %0d, expected 31", InstrCount); end
        tests++; if (Halted !== 1'b1)       begin fails++; $display("FAIL wrap_halt: got %b, expected 1", Halted); end
        tests++; if (exp_q.size() != 0)     begin fails++; $display("FAIL wrap_queue: %0d entries left, expected 0", exp_q.size()); end
    endtask

    task automatic test_stop_exec();
        apply_reset();
        rom[0] = 16'h0280;
        rom[1] = 16'h0280;
        exp_q.push_back('{din: 16'h0280, last: 1'b0});
        exp_q.push_back('{din: 16'h0280, last: 1'b0});
        exp_q.push_back('{din: 16'h0280, last: 1'b1});
        pulse_start();
        wait_for("stop_run", 1'b0, 1'b1, 20);
        Stop = 1'b1;
        @(negedge Clock);
        Stop = 1'b0;
        wait_for("stop_gap", 1'b0, 1'b0, 20);
        tests++; if (Busy !== 1'b1)        begin fails++; $display("FAIL stop_gap_busy: got %b, expected 1", Busy); end
        tests++; if (PC !== 5'd1)          begin fails++; $display("FAIL stop_pc: got %0d, expected 1", PC); end
        tests++; if (InstrCount !== 16'd1) begin fails++; $display("FAIL stop_count: got %0d, expected 1", InstrCount); end
        @(negedge Clock);
        tests++; if (Busy !== 1'b0)        begin fails++; $display("FAIL stop_idle: Busy got %b, expected 0", Busy); end
        repeat (3) @(negedge Clock);
        tests++; if (Busy !== 1'b0)        begin fails++; $display("FAIL stop_stay: Busy got %b, expected 0", Busy); end
    endtask

    task automatic test_stop_fetch();
        apply_reset();
        rom[0] = 16'h0280;
        @(negedge Clock);
        Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        Stop  = 1'b1;
        @(negedge Clock);
        Stop = 1'b0;
        tests++; if (Busy !== 1'b0)  begin fails++; $display("FAIL fstop_busy: got %b, expected 0", Busy); end
        tests++; if (PC !== 5'd0)    begin fails++; $display("FAIL fstop_pc: got %0d, expected 0", PC); end
        repeat (4) @(negedge Clock);
        tests++; if (Busy !== 1'b0)  begin fails++; $display("FAIL fstop_stay: Busy got %b, expected 0", Busy); end
    endtask

    task automatic test_async_reset();
        apply_reset();
        rom[0] = 16'h0280;
        rom[1] = 16'h0280;
        exp_q.push_back('{din: 16'h0280, last: 1'b1});
        exp_q.push_back('{din: 16'h0280, last: 1'b0});
        exp_q.push_back('{din: 16'h0280, last: 1'b0});
        pulse_start();
        wait_for("ar_run0", 1'b0, 1'b1, 20);
        wait_for("ar_gap", 1'b0, 1'b0, 20);
        wait_for("ar_run1", 1'b0, 1'b1, 20);
        tests++; if (InstrCount !== 16'd1) begin fails++; $display("FAIL ar_count_pre: got %0d, expected 1", InstrCount); end
        @(negedge Clock);
        #2;
        Reset = 1'b1;
        #1;
        tests++; if (Run !== 1'b0)         begin fails++; $display("FAIL ar_run: got %b, expected 0", Run); end
        tests++; if (PC !== 5'd0)          begin fails++; $display("FAIL ar_pc: got %0d, expected 0", PC); end
        tests++; if (InstrCount !== 16'd0) begin fails++; $display("FAIL ar_count: got %0d, expected 0", InstrCount); end
        tests++; if (Busy !== 1'b0)        begin fails++; $display("FAIL ar_busy: got %b, expected 0", Busy); end
        @(negedge Clock);
        Reset = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge Clock);
        tests++; if (Busy !== 1'b0)        begin fails++; $display("FAIL ar_idle: Busy got %b, expected 0", Busy); end
    endtask

    initial begin
        Reset = 1'b1;
        Start = 1'b0;
        Stop  = 1'b0;
        Done  = 1'b0;
        for (int i = 0; i < 32; i++) rom[i] = 16'h0000;
        test_reset();
        test_program();
        test_wrap();
        test_stop_exec();
        test_stop_fetch();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
